// File: rtl/f2h_uart_tx_master.sv
// AXI3 master that buffers a byte stream and writes it into the HPS UART THR over F2H.
// Define F2H_UART_POLL_GAP_EN to hold POLL_GAP idle cycles between LSR polls.
module f2h_uart_tx_master #(
    parameter logic [31:0] UART_BASE  = 32'hFFC02000,
    parameter int          FIFO_DEPTH = 16,
    parameter int          TX_BATCH   = 16,
    parameter logic [7:0]  AXI_ID     = 8'h00,
    parameter int          POLL_GAP   = 64
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [7:0]                    s_data,
    input  logic                          s_valid,
    output logic                          s_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          busy,
    output logic                          err,
    output logic [7:0]                    m_awid,
    output logic [31:0]                   m_awaddr,
    output logic [3:0]                    m_awlen,
    output logic [2:0]                    m_awsize,
    output logic [1:0]                    m_awburst,
    output logic [1:0]                    m_awlock,
    output logic [3:0]                    m_awcache,
    output logic [2:0]                    m_awprot,
    output logic [4:0]                    m_awuser,
    output logic                          m_awvalid,
    input  logic                          m_awready,
    output logic [7:0]                    m_wid,
    output logic [31:0]                   m_wdata,
    output logic [3:0]                    m_wstrb,
    output logic                          m_wlast,
    output logic                          m_wvalid,
    input  logic                          m_wready,
    input  logic [7:0]                    m_bid,
    input  logic [1:0]                    m_bresp,
    input  logic                          m_bvalid,
    output logic                          m_bready,
    output logic [7:0]                    m_arid,
    output logic [31:0]                   m_araddr,
    output logic [3:0]                    m_arlen,
    output logic [2:0]                    m_arsize,
    output logic [1:0]                    m_arburst,
    output logic [1:0]                    m_arlock,
    output logic [3:0]                    m_arcache,
    output logic [2:0]                    m_arprot,
    output logic [4:0]                    m_aruser,
    output logic                          m_arvalid,
    input  logic                          m_arready,
    input  logic [7:0]                    m_rid,
    input  logic [31:0]                   m_rdata,
    input  logic [1:0]                    m_rresp,
    input  logic                          m_rlast,
    input  logic                          m_rvalid,
    output logic                          m_rready
);
    localparam int            AW       = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]   FULL_LVL = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW:0]   ONE_LVL  = (AW + 1)'(1);

    typedef enum logic [2:0] {IDLE, POLL_AR, POLL_R, GAP, WR, WAIT_B} state_t;

    state_t        state_q;
    logic          arvalid_q, rready_q, awvalid_q, wvalid_q, bready_q, err_q;
    logic [31:0]   wdata_q;
    logic [7:0]    batch_q;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_nxt;
    logic [AW:0]   count_q, count_d;
    logic          push, pop;
    logic [7:0]    head, next_head;
`ifdef F2H_UART_POLL_GAP_EN
    logic [15:0]   gap_q;
`endif

    assign push       = s_valid && s_ready;
    assign pop        = bready_q && m_bvalid;
    assign rd_ptr_nxt = rd_ptr_q + AW'(1);
    assign head       = mem_q[rd_ptr_q];
    // A byte pushed while the only stored byte is being popped becomes the new head this edge.
    assign next_head  = (push && count_q == ONE_LVL) ? s_data : mem_q[rd_ptr_nxt];

    // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + ONE_LVL;
            2'b01:   count_d = count_q - ONE_LVL;
            default: count_d = count_q;
        endcase
    end

    // NOTE: the storage array is deliberately not reset; occupancy is tracked by the reset pointers.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= s_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_nxt;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            err_q     <= 1'b0;
            wdata_q   <= '0;
            batch_q   <= '0;
`ifdef F2H_UART_POLL_GAP_EN
            gap_q     <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: if (count_q != '0) state_q <= POLL_AR;
                POLL_AR: begin
                    if (!arvalid_q) begin
                        arvalid_q <= 1'b1;
                    end else if (m_arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= POLL_R;
                    end
                end
                POLL_R: begin
                    if (m_rvalid) begin
                        rready_q <= 1'b0;
                        if (m_rresp != 2'b00) err_q <= 1'b1;
                        // An errored LSR read is treated as THRE clear.
                        if (m_rresp == 2'b00 && m_rdata[5]) begin
                            batch_q   <= 8'(TX_BATCH);
                            wdata_q   <= {24'h0, head};
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state_q   <= WR;
                        end else begin
`ifdef F2H_UART_POLL_GAP_EN
                            gap_q   <= 16'(POLL_GAP - 1);
`endif
                            state_q <= GAP;
                        end
                    end
                end
                GAP: begin
`ifdef F2H_UART_POLL_GAP_EN
                    if (gap_q == '0) begin
                        arvalid_q <= 1'b1;
                        state_q   <= POLL_AR;
                    end else begin
                        gap_q <= gap_q - 16'd1;
                    end
`else
                    arvalid_q <= 1'b1;
                    state_q   <= POLL_AR;
`endif
                end
                WR: begin
                    if (awvalid_q && m_awready) awvalid_q <= 1'b0;
                    if (wvalid_q && m_wready)   wvalid_q  <= 1'b0;
                    if ((!awvalid_q || m_awready) && (!wvalid_q || m_wready)) begin
                        bready_q <= 1'b1;
                        state_q  <= WAIT_B;
                    end
                end
                WAIT_B: begin
                    if (m_bvalid) begin
                        bready_q <= 1'b0;
                        if (m_bresp != 2'b00) err_q <= 1'b1;
                        batch_q <= batch_q - 8'd1;
                        if (count_d == '0) begin
                            state_q <= IDLE;
                        end else if (batch_q != 8'd1) begin
                            wdata_q   <= {24'h0, next_head};
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state_q   <= WR;
                        end else begin
                            arvalid_q <= 1'b1;
                            state_q   <= POLL_AR;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign s_ready    = (count_q != FULL_LVL);
    assign fifo_level = count_q;
    assign busy       = (state_q != IDLE) || (count_q != '0);
    assign err        = err_q;

    assign m_awid    = AXI_ID;
    assign m_awaddr  = UART_BASE;
    assign m_awlen   = 4'd0;
    assign m_awsize  = 3'b010;
    assign m_awburst = 2'b01;
    assign m_awlock  = 2'b00;
    assign m_awcache = 4'd0;
    assign m_awprot  = 3'd0;
    assign m_awuser  = 5'd0;
    assign m_awvalid = awvalid_q;
    assign m_wid     = AXI_ID;
    assign m_wdata   = wdata_q;
    assign m_wstrb   = 4'b0001;
    assign m_wlast   = 1'b1;
    assign m_wvalid  = wvalid_q;
    assign m_bready  = bready_q;
    assign m_arid    = AXI_ID;
    assign m_araddr  = UART_BASE + 32'h14;
    assign m_arlen   = 4'd0;
    assign m_arsize  = 3'b010;
    assign m_arburst = 2'b01;
    assign m_arlock  = 2'b00;
    assign m_arcache = 4'd0;
    assign m_arprot  = 3'd0;
    assign m_aruser  = 5'd0;
    assign m_arvalid = arvalid_q;
    assign m_rready  = rready_q;

    // Only one transaction is ever outstanding, so IDs and RLAST carry no information.
    logic unused_inputs;
    assign unused_inputs = ^{m_bid, m_rid, m_rlast, m_rdata[31:6], m_rdata[4:0]};
`ifndef F2H_UART_POLL_GAP_EN
    logic unused_gap;
    assign unused_gap = (POLL_GAP != 0);
`endif
endmodule

// File: doc/f2h_uart_tx_master.md
# f2h_uart_tx_master

Upstream AXI3 master feeding the HPS FPGA-to-HPS (F2H) AXI slave port. It accepts a byte stream from FPGA logic and buffers it in a local FIFO. It polls the HPS UART line-status register over F2H and writes bytes into the UART transmit holding register when the UART TX FIFO is empty. It sits in the FPGA fabric, clocked by the bridge clock, between user logic and the `hps_0_f2h_axi_slave` port of the SoC system.

## Interface
**Parameters**
- `UART_BASE`, 32'hFFC02000: HPS UART byte address. THR is at offset 0x00; LSR is at offset 0x14.
- `FIFO_DEPTH`, 16: input FIFO entries. Must be a power of 2, at least 2.
- `TX_BATCH`, 16: maximum bytes written per observed THRE. Range 1..128; must be 1 if the UART FIFOs are disabled.
- `AXI_ID`, 8'h00: value driven on `awid`, `wid` and `arid`.
- `POLL_GAP`, 64: idle cycles between LSR polls (macro-dependent).

**Ports**
- `clk` in 1: bridge clock, the same clock as the F2H slave.
- `reset_n` in 1: asynchronous active-low reset.
- `s_data` in 8: byte to transmit.
- `s_valid` in 1, `s_ready` out 1: input handshake. A byte is accepted when both are high.
- `fifo_level` out log2(FIFO_DEPTH)+1: current occupancy of the input FIFO.
- `busy` out 1: high when the state is not IDLE or the FIFO is not empty.
- `err` out 1: sticky; set by any non-OKAY `rresp` or `bresp`; cleared only by reset.
- AW channel (out): `m_awid` 8, `m_awaddr` 32, `m_awlen` 4, `m_awsize` 3, `m_awburst` 2, `m_awlock` 2, `m_awcache` 4, `m_awprot` 3, `m_awuser` 5, `m_awvalid` 1; (in) `m_awready` 1.
- W channel (out): `m_wid` 8, `m_wdata` 32, `m_wstrb` 4, `m_wlast` 1, `m_wvalid` 1; (in) `m_wready` 1.
- B channel (in): `m_bid` 8, `m_bresp` 2, `m_bvalid` 1; (out) `m_bready` 1.
- AR channel (out): `m_arid` 8, `m_araddr` 32, `m_arlen` 4, `m_arsize` 3, `m_arburst` 2, `m_arlock` 2, `m_arcache` 4, `m_arprot` 3, `m_aruser` 5, `m_arvalid` 1; (in) `m_arready` 1.
- R channel (in): `m_rid` 8, `m_rdata` 32, `m_rresp` 2, `m_rlast` 1, `m_rvalid` 1; (out) `m_rready` 1.

## Operation
- **Constant AXI fields:**
  - len=0, size=3'b010, burst=2'b01, lock=0, cache=0, prot=0, user=0.
  - `wstrb`=4'b0001, `wlast`=1, `wdata`={24'h0, FIFO head}.
- **Addresses:** `araddr`=UART_BASE+0x14; `awaddr`=UART_BASE.
- **FIFO:**
  - `s_ready`=!full.
  - Push and pop in the same cycle leave the level unchanged.
  - A push while full is ignored, since `s_ready` is low.
  - Pop happens in the cycle of the B handshake.
- **FSM states:** IDLE, POLL_AR, POLL_R, GAP, WR, WAIT_B.
  - IDLE: if the FIFO is not empty, go to POLL_AR.
  - POLL_AR: `arvalid`=1; on `arready`, go to POLL_R.
  - POLL_R: `rready`=1; on `rvalid`:
    - if `rresp`≠0, set `err` and treat the result as THRE=0;
    - if `rdata[5]`=1, load `batch_cnt`=TX_BATCH and go to WR;
    - otherwise go to GAP.
  - GAP: wait, then go to POLL_AR.
  - WR: `awvalid`=`wvalid`=1 on entry. Each drops independently after its own handshake. When both are done, go to WAIT_B.
  - WAIT_B: `bready`=1; on `bvalid`:
    - set `err` if `bresp`≠0;
    - pop the byte (including on error; the byte is dropped);
    - decrement `batch_cnt`;
    - if the FIFO is now empty, go to IDLE;
    - else if `batch_cnt`≠0, go to WR;
    - else go to POLL_AR.
- **Response matching:** `bid`, `rid` and `rlast` are ignored; only one transaction is outstanding at a time.
- **Reset mid-transaction:** all valids drop immediately and the FIFO is emptied. The F2H slave is reset by the same domain, so no handshake completion is required.

## Timing
- **Reset values:**
  - all `m_*valid`, `m_bready`, `m_rready` = 0;
  - `s_ready`=1, `fifo_level`=0, `busy`=0, `err`=0;
  - `wdata` = 0; address/ID fields = their constants.
- **Registered outputs:** all valids and readies are registered. Valids stay stable until the handshake (AXI rule: no dependency on ready).
- **Latency from push into an empty FIFO:** `s_valid` is accepted at edge N; `arvalid` rises at N+2 (IDLE at N+1, POLL_AR at N+2).
- **R to W:** an R beat with THRE=1 at edge M gives `awvalid`/`wvalid` at M+1.
- **B to next write:** a B handshake at edge K gives the next `awvalid` at K+1 when the batch is not exhausted.
- **Readiness:** `rready`/`bready` are asserted for the whole POLL_R/WAIT_B state; zero-cycle accept.
- **Input path:** `fifo_level` updates the edge after a push or pop. `s_ready` deasserts the cycle after the push that fills the FIFO.

## Configuration
- **`F2H_UART_POLL_GAP_EN` defined:** GAP holds for POLL_GAP cycles, using a counter loaded on entry, before POLL_AR.
- **Undefined:** GAP lasts exactly 1 cycle, giving back-to-back polling. The POLL_GAP parameter is unused.

## Test plan
- **Reset:** assert `reset_n`=0 mid-WR with `awvalid`=1 → `awvalid`/`wvalid`=0 and `fifo_level`=0 in the same cycle; `s_ready`=1 and `err`=0 after release.
- **Single byte:** push 0x41; slave returns `rdata`=0x60 → one AR to 0xFFC02014, then AW to 0xFFC02000 with `wdata`=0x00000041, `wstrb`=0001, len 0, size 2; `busy` drops after B.
- **THRE not set:** LSR reads 0x00 three times, then 0x20 → exactly 4 AR transactions, then 1 write. With the macro defined and POLL_GAP=64, consecutive `arvalid` rises are ≥65 cycles apart.
- **Batching:** TX_BATCH=16; push 20 bytes 0x00..0x13 → 1 poll, 16 writes 0x00..0x0F, 1 poll, 4 writes 0x10..0x13, in order.
- **AW/W skew and back-pressure:**
  - `awready` 3 cycles late with `wready` immediate (then swapped) → exactly one AW and one W handshake per byte.
  - `arready` held low, 17 pushes with FIFO_DEPTH=16 → `s_ready`=0 after the 16th; `fifo_level`=16.
- **Error:** `bresp`=2'b10 on byte 0x55 → `err`=1 and stays set; 0x55 is not retried; the next byte 0x56 is written normally.
